// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: branch outcome encoding and the feedback-queue entry
// layout used between fetch-side prediction and execute-side resolution.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef struct packed {
        logic [`ADDR_WIDTH-1:0] pc;
        logic [`ADDR_WIDTH-1:0] target;
        BranchOutcome           prediction;
    } branch_fb_entry_t;

    localparam int unsigned DELAY_SLOT_OFFSET = 8;

    // Not-taken branches resume past the delay slot; wraps modulo 2^ADDR_WIDTH.
    function automatic logic [`ADDR_WIDTH-1:0] redirect_target(
        input branch_fb_entry_t entry,
        input BranchOutcome     outcome
    );
        if (outcome == TAKEN) begin
            return entry.target;
        end else begin
            return entry.pc + `ADDR_WIDTH'(DELAY_SLOT_OFFSET);
        end
    endfunction

endpackage

// File: rtl/branch_fb_queue_sat_counter.sv
// Saturating up-counter: increments on inc_i and holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] value_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next value: step by one unless already saturated.
    always_comb begin
        value_d = value_q;
        if (inc_i && (value_q != MAX_VAL)) begin
            value_d = value_q + ONE_VAL;
        end else begin
            value_d = value_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= {WIDTH{1'b0}};
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/branch_fb_queue.sv
// In-order branch feedback queue: pairs fetch-time predictions with execute
// resolutions, drives predictor feedback and flushes wrong-path entries.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_fb_queue
    import mips_core_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CNT_BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_req_valid,
    input  logic [`ADDR_WIDTH-1:0]     i_req_pc,
    input  logic [`ADDR_WIDTH-1:0]     i_req_target,
    input  BranchOutcome               i_req_prediction,
    output logic                       o_req_ready,
    input  logic                       i_res_valid,
    input  BranchOutcome               i_res_outcome,
    output logic                       o_fb_valid,
    output logic [`ADDR_WIDTH-1:0]     o_fb_pc,
    output BranchOutcome               o_fb_prediction,
    output BranchOutcome               o_fb_outcome,
    output logic                       o_mispredict,
    output logic [`ADDR_WIDTH-1:0]     o_redirect_pc,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_underflow,
    output logic [CNT_BITS-1:0]        o_branch_cnt,
    output logic [CNT_BITS-1:0]        o_mispredict_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    branch_fb_entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]            head_q, head_d;
    logic [PTR_W-1:0]            tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;

    logic                        fb_valid_q;
    logic [`ADDR_WIDTH-1:0]      fb_pc_q;
    BranchOutcome                fb_prediction_q;
    BranchOutcome                fb_outcome_q;
    logic                        mispredict_q;
    logic [`ADDR_WIDTH-1:0]      redirect_pc_q;
    logic                        underflow_q;

    branch_fb_entry_t            head_entry_s;
    branch_fb_entry_t            req_entry_s;
    logic                        ready_s;
    logic                        pop_s;
    logic                        push_s;
    logic                        mispredict_pending_s;

    // Resolve/enqueue decode; a mispredicting resolve kills any same-cycle enqueue.
    always_comb begin
        head_entry_s            = mem_q[head_q];
        req_entry_s.pc          = i_req_pc;
        req_entry_s.target      = i_req_target;
        req_entry_s.prediction  = i_req_prediction;
        ready_s                 = (count_q < CNT_FULL);
        pop_s                   = i_res_valid && (count_q != CNT_ZERO);
        mispredict_pending_s    = pop_s && (head_entry_s.prediction != i_res_outcome);
        push_s                  = i_req_valid && ready_s && !mispredict_pending_s;
    end

    // Pointer and occupancy next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict_pending_s) begin
            head_d  = head_q + PTR_ONE;
            tail_d  = head_q + PTR_ONE;
            count_d = CNT_ZERO;
        end else begin
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            if (push_s) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= CNT_ZERO;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[tail_q] <= req_entry_s;
        end
    end

    // Registered feedback, redirect and sticky underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_valid_q      <= 1'b0;
            fb_pc_q         <= {`ADDR_WIDTH{1'b0}};
            fb_prediction_q <= NOT_TAKEN;
            fb_outcome_q    <= NOT_TAKEN;
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= {`ADDR_WIDTH{1'b0}};
            underflow_q     <= 1'b0;
        end else begin
            fb_valid_q   <= pop_s;
            mispredict_q <= mispredict_pending_s;
            underflow_q  <= underflow_q || (i_res_valid && (count_q == CNT_ZERO));
            if (pop_s) begin
                fb_pc_q         <= head_entry_s.pc;
                fb_prediction_q <= head_entry_s.prediction;
                fb_outcome_q    <= i_res_outcome;
            end
            if (mispredict_pending_s) begin
                redirect_pc_q <= redirect_target(head_entry_s, i_res_outcome);
            end
        end
    end

    sat_counter #(.WIDTH(CNT_BITS)) u_branch_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (pop_s),
        .value_o (o_branch_cnt)
    );

    sat_counter #(.WIDTH(CNT_BITS)) u_mispredict_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (mispredict_pending_s),
        .value_o (o_mispredict_cnt)
    );

    assign o_req_ready     = ready_s;
    assign o_count         = count_q;
    assign o_fb_valid      = fb_valid_q;
    assign o_fb_pc         = fb_pc_q;
    assign o_fb_prediction = fb_prediction_q;
    assign o_fb_outcome    = fb_outcome_q;
    assign o_mispredict    = mispredict_q;
    assign o_redirect_pc   = redirect_pc_q;
    assign o_underflow     = underflow_q;

endmodule

// File: tb/tb_branch_fb_queue.sv
// Directed self-checking bench for branch_fb_queue (DEPTH=8, 4-bit counters
// so saturation is reachable).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_fb_queue;
    import mips_core_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   i_req_valid;
    logic [`ADDR_WIDTH-1:0] i_req_pc;
    logic [`ADDR_WIDTH-1:0] i_req_target;
    BranchOutcome           i_req_prediction;
    logic                   o_req_ready;
    logic                   i_res_valid;
    BranchOutcome           i_res_outcome;
    logic                   o_fb_valid;
    logic [`ADDR_WIDTH-1:0] o_fb_pc;
    BranchOutcome           o_fb_prediction;
    BranchOutcome           o_fb_outcome;
    logic                   o_mispredict;
    logic [`ADDR_WIDTH-1:0] o_redirect_pc;
    logic [3:0]             o_count;
    logic                   o_underflow;
    logic [3:0]             o_branch_cnt;
    logic [3:0]             o_mispredict_cnt;

    int checks = 0;
    int errors = 0;

    branch_fb_queue #(.DEPTH(8), .CNT_BITS(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (i_req_valid),
        .i_req_pc         (i_req_pc),
        .i_req_target     (i_req_target),
        .i_req_prediction (i_req_prediction),
        .o_req_ready      (o_req_ready),
        .i_res_valid      (i_res_valid),
        .i_res_outcome    (i_res_outcome),
        .o_fb_valid       (o_fb_valid),
        .o_fb_pc          (o_fb_pc),
        .o_fb_prediction  (o_fb_prediction),
        .o_fb_outcome     (o_fb_outcome),
        .o_mispredict     (o_mispredict),
        .o_redirect_pc    (o_redirect_pc),
        .o_count          (o_count),
        .o_underflow      (o_underflow),
        .o_branch_cnt     (o_branch_cnt),
        .o_mispredict_cnt (o_mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance past the edge and idle the inputs.
    task automatic step(input logic rv, input logic [31:0] pc, input logic [31:0] tgt,
                        input BranchOutcome pred, input logic sv, input BranchOutcome oc);
        i_req_valid = rv; i_req_pc = pc; i_req_target = tgt; i_req_prediction = pred;
        i_res_valid = sv; i_res_outcome = oc;
        @(posedge clk); #1;
        i_req_valid = 1'b0; i_res_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", o_count); end
        checks++; if (o_fb_valid !== 1'b0) begin errors++; $display("FAIL reset_fb_valid: got %b expected 0", o_fb_valid); end
        checks++; if (o_fb_prediction !== NOT_TAKEN) begin errors++; $display("FAIL reset_fb_pred: got %0d expected 0", o_fb_prediction); end
        checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", o_underflow); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_req_ready); end
        checks++; if (o_branch_cnt !== 4'd0) begin errors++; $display("FAIL reset_branch_cnt: got %0d expected 0", o_branch_cnt); end
    endtask

    task automatic test_basic();
        step(1'b1, 32'h100, 32'h200, TAKEN, 1'b0, NOT_TAKEN);
        checks++; if (o_count !== 4'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", o_count); end
        checks++; if (o_fb_valid !== 1'b0) begin errors++; $display("FAIL basic_early_fb: got %b expected 0", o_fb_valid); end
        step(1'b0, 32'h0, 32'h0, NOT_TAKEN, 1'b1, TAKEN);
        checks++; if (o_fb_valid !== 1'b1) begin errors++; $display("FAIL basic_fb_valid: got %b expected 1", o_fb_valid); end
        checks++; if (o_fb_pc !== 32'h100) begin errors++; $display("FAIL basic_fb_pc: got %h expected 100", o_fb_pc); end
        checks++; if (o_fb_outcome !== TAKEN) begin errors++; $display("FAIL basic_fb_outcome: got %0d expected 1", o_fb_outcome); end
        checks++; if (o_mispredict !== 1'b0) begin errors++; $display("FAIL basic_mispredict: got %b expected 0", o_mispredict); end
        checks++; if (o_branch_cnt !== 4'd1) begin errors++; $display("FAIL basic_branch_cnt: got %0d expected 1", o_branch_cnt); end
        step(1'b0, 32'h0, 32'h0, NOT_TAKEN, 1'b0, NOT_TAKEN);
        checks++; if (o_fb_valid !== 1'b0) begin errors++; $display("FAIL basic_fb_pulse: got %b expected 0", o_fb_valid); end
    endtask

    task automatic test_mispredict();
        step(1'b1, 32'h100, 32'h180, TAKEN, 1'b0, NOT_TAKEN);
        step(1'b1, 32'h110, 32'h190, TAKEN, 1'b0, NOT_TAKEN);
        step(1'b1, 32'h120, 32'h1a0, TAKEN, 1'b0, NOT_TAKEN);
        checks++; if (o_count !== 4'd3) begin errors++; $display("FAIL mp_fill_count: got %0d expected 3", o_count); end
        step(1'b1, 32'h130, 32'h1b0, TAKEN, 1'b1, NOT_TAKEN);
        checks++; if (o_mispredict !== 1'b1) begin errors++; $display("FAIL mp_pulse: got %b expected 1", o_mispredict); end
        checks++; if (o_redirect_pc !== 32'h108) begin errors++; $display("FAIL mp_redirect: got %h expected 108", o_redirect_pc); end
        checks++; if (o_fb_valid !== 1'b1) begin errors++; $display("FAIL mp_fb_valid: got %b expected 1", o_fb_valid); end
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL mp_flush_count: got %0d expected 0", o_count); end
        checks++; if (o_mispredict_cnt !== 4'd1) begin errors++; $display("FAIL mp_cnt: got %0d expected 1", o_mispredict_cnt); end
        step(1'b1, 32'h140, 32'h1c0, TAKEN, 1'b0, NOT_TAKEN);
        checks++; if (o_mispredict !== 1'b0) begin errors++; $display("FAIL mp_pulse_end: got %b expected 0", o_mispredict); end
        checks++; if (o_count !== 4'd1) begin errors++; $display("FAIL mp_post_enq: got %0d expected 1", o_count); end
        step(1'b0, 32'h0, 32'h0, NOT_TAKEN, 1'b1, TAKEN);
        checks++; if (o_fb_pc !== 32'h140) begin errors++; $display("FAIL mp_post_fb_pc: got %h expected 140", o_fb_pc); end
        checks++; if (o_branch_cnt !== 4'd3) begin errors++; $display("FAIL mp_branch_cnt: got %0d expected 3", o_branch_cnt); end
    endtask

    task automatic test_taken_redirect();
        step(1'b1, 32'h300, 32'h400, NOT_TAKEN, 1'b0, NOT_TAKEN);
        step(1'b0, 32'h0, 32'h0, NOT_TAKEN, 1'b1, TAKEN);
        checks++; if (o_mispredict !== 1'b1) begin errors++; $display("FAIL tk_pulse: got %b expected 1", o_mispredict); end
        checks++; if (o_redirect_pc !== 32'h400) begin errors++; $display("FAIL tk_redirect: got %h expected 400", o_redirect_pc); end
        checks++; if (o_fb_prediction !== NOT_TAKEN) begin errors++; $display("FAIL tk_fb_pred: got %0d expected 0", o_fb_prediction); end
        checks++; if (o_mispredict_cnt !== 4'd2) begin errors++; $display("FAIL tk_cnt: got %0d expected 2", o_mispredict_cnt); end
    endtask

    task automatic test_full_and_wrap();
        logic [31:0] exp_q[$];
        logic [31:0] exp_pc;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h1000 + 32'(i * 4), 32'h0, NOT_TAKEN, 1'b0, NOT_TAKEN);
            exp_q.push_back(32'h1000 + 32'(i * 4));
        end
        checks++; if (o_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", o_count); end
        checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", o_req_ready); end
        step(1'b1, 32'h2000, 32'h0, NOT_TAKEN, 1'b0, NOT_TAKEN);
        checks++; if (o_count !== 4'd8) begin errors++; $display("FAIL full_drop: got %0d expected 8", o_count); end
        step(1'b1, 32'h3000, 32'h0, NOT_TAKEN, 1'b1, NOT_TAKEN);
        exp_pc = exp_q.pop_front();
        checks++; if (o_fb_pc !== exp_pc) begin errors++; $display("FAIL full_pop_pc: got %h expected %h", o_fb_pc, exp_pc); end
        checks++; if (o_count !== 4'd7) begin errors++; $display("FAIL full_pop_count: got %0d expected 7", o_count); end
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise: got %b expected 1", o_req_ready); end
        for (int j = 0; j < 16; j++) begin
            step(1'b1, 32'h4000 + 32'(j * 4), 32'h0, NOT_TAKEN, 1'b1, NOT_TAKEN);
            exp_pc = exp_q.pop_front();
            exp_q.push_back(32'h4000 + 32'(j * 4));
            checks++; if (o_fb_valid !== 1'b1 || o_fb_pc !== exp_pc) begin errors++; $display("FAIL wrap_pair_%0d: got valid=%b pc=%h expected valid=1 pc=%h", j, o_fb_valid, o_fb_pc, exp_pc); end
        end
        checks++; if (o_count !== 4'd7) begin errors++; $display("FAIL wrap_count: got %0d expected 7", o_count); end
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 32'h0, 32'h0, NOT_TAKEN, 1'b1, NOT_TAKEN);
            exp_pc = exp_q.pop_front();
            checks++; if (o_fb_pc !== exp_pc) begin errors++; $display("FAIL drain_%0d: got %h expected %h", k, o_fb_pc, exp_pc); end
        end
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", o_count); end
    endtask

    task automatic test_underflow();
        step(1'b0, 32'h0, 32'h0, NOT_TAKEN, 1'b1, TAKEN);
        checks++; if (o_fb_valid !== 1'b0) begin errors++; $display("FAIL uf_fb_valid: got %b expected 0", o_fb_valid); end
        checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", o_underflow); end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, NOT_TAKEN, 1'b0, NOT_TAKEN);
        checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", o_underflow); end
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL uf_count: got %0d expected 0", o_count); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'h500, 32'h600, TAKEN, 1'b0, NOT_TAKEN);
        step(1'b1, 32'h510, 32'h610, TAKEN, 1'b0, NOT_TAKEN);
        step(1'b0, 32'h0, 32'h0, NOT_TAKEN, 1'b1, NOT_TAKEN);
        checks++; if (o_mispredict !== 1'b1 || o_redirect_pc !== 32'h508) begin errors++; $display("FAIL rm_pre: got mp=%b pc=%h expected mp=1 pc=508", o_mispredict, o_redirect_pc); end
        rst_n = 1'b0; #1;
        checks++; if (o_fb_valid !== 1'b0 || o_mispredict !== 1'b0) begin errors++; $display("FAIL rm_strobes: got fb=%b mp=%b expected 0 0", o_fb_valid, o_mispredict); end
        checks++; if (o_fb_pc !== 32'h0 || o_redirect_pc !== 32'h0) begin errors++; $display("FAIL rm_pcs: got fb_pc=%h redir=%h expected 0 0", o_fb_pc, o_redirect_pc); end
        checks++; if (o_fb_prediction !== NOT_TAKEN || o_fb_outcome !== NOT_TAKEN) begin errors++; $display("FAIL rm_dirs: got pred=%0d out=%0d expected 0 0", o_fb_prediction, o_fb_outcome); end
        checks++; if (o_count !== 4'd0 || o_underflow !== 1'b0) begin errors++; $display("FAIL rm_state: got count=%0d uf=%b expected 0 0", o_count, o_underflow); end
        checks++; if (o_branch_cnt !== 4'd0 || o_mispredict_cnt !== 4'd0) begin errors++; $display("FAIL rm_cnts: got br=%0d mp=%0d expected 0 0", o_branch_cnt, o_mispredict_cnt); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b expected 1", o_req_ready); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h700 + 32'(i * 8), 32'h0, TAKEN, 1'b0, NOT_TAKEN);
            step(1'b0, 32'h0, 32'h0, NOT_TAKEN, 1'b1, TAKEN);
            exp_cnt = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            checks++; if (o_branch_cnt !== exp_cnt) begin errors++; $display("FAIL sat_%0d: got %0d expected %0d", i, o_branch_cnt, exp_cnt); end
        end
        checks++; if (o_mispredict_cnt !== 4'd0) begin errors++; $display("FAIL sat_mp_cnt: got %0d expected 0", o_mispredict_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        i_req_valid = 1'b0; i_req_pc = 32'h0; i_req_target = 32'h0; i_req_prediction = NOT_TAKEN;
        i_res_valid = 1'b0; i_res_outcome = NOT_TAKEN;
        test_reset();
        test_basic();
        test_mispredict();
        test_taken_redirect();
        test_full_and_wrap();
        test_underflow();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
